// File: rtl/ped_emerg_input_conditioner.sv
// ped_emerg_input_conditioner
//
// Conditions the two asynchronous, bouncy field inputs of a pedestrian
// crossing controller. It produces a latched pedestrian request and a
// hold-extended emergency level.
//
// Each raw input passes through a 2-flop synchronizer and then an
// independent debouncer. The debounced button's rising edge latches a
// request while the crossing is idle. The debounced emergency level drives
// a small FSM (E_IDLE / E_ACTIVE / E_HOLD). That FSM keeps the emergency
// output asserted for EMERG_HOLD_CYCLES after the detector drops, and it
// pre-empts any pending pedestrian request.
//
// Ports
//   clk                 in   single clock, rising edge
//   rst                 in   synchronous, active-high reset
//   ped_button_raw      in   asynchronous pedestrian push-button
//   emergency_raw       in   asynchronous emergency-vehicle detector
//   ped_served          in   high while downstream shows WALK; clears request
//   pedestrian_request  out  latched, not-yet-served pedestrian request
//   emergency           out  debounced, hold-extended emergency level
//   req_count[7:0]      out  saturating count of accepted requests
module ped_emerg_input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int EMERG_HOLD_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_button_raw,
  input  logic       emergency_raw,
  input  logic       ped_served,
  output logic       pedestrian_request,
  output logic       emergency,
  output logic [7:0] req_count
);

  localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LAST = 8'(EMERG_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    E_IDLE   = 2'd0,
    E_ACTIVE = 2'd1,
    E_HOLD   = 2'd2
  } emg_state_t;

  // One debouncer step, returned as {next_state, next_count}. The count
  // runs only while the synchronized level disagrees with the accepted
  // level. Once the count reaches DB_LAST, the level has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles, and the new level is taken.
  function automatic logic [8:0] debounce_step(input logic       sync,
                                               input logic       state,
                                               input logic [7:0] cnt);
    logic [8:0] res;
    if (sync == state)
      res = {state, 8'd0};
    else if (cnt == DB_LAST)
      res = {sync, 8'd0};
    else
      res = {state, cnt + 8'd1};
    return res;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic       ped_sync_p0, ped_sync_p1;
  logic       emg_sync_p0, emg_sync_p1;
  logic       ped_db, emg_db, ped_db_d;
  logic [7:0] ped_db_cnt, emg_db_cnt;
  logic [8:0] ped_db_nxt, emg_db_nxt;

  emg_state_t state, state_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic       press_rise, accept, enter_active;
  logic       req_nxt;
  logic [7:0] count_nxt;

  // Stage p0/p1: metastability synchronizers
  always_ff @(posedge clk) begin
    if (rst) begin
      ped_sync_p0 <= 1'b0;
      ped_sync_p1 <= 1'b0;
      emg_sync_p0 <= 1'b0;
      emg_sync_p1 <= 1'b0;
    end else begin
      ped_sync_p0 <= ped_button_raw;
      ped_sync_p1 <= ped_sync_p0;
      emg_sync_p0 <= emergency_raw;
      emg_sync_p1 <= emg_sync_p0;
    end
  end

  // Stage p2: debouncers, plus a delayed copy of the button for edge detect
  assign ped_db_nxt = debounce_step(ped_sync_p1, ped_db, ped_db_cnt);
  assign emg_db_nxt = debounce_step(emg_sync_p1, emg_db, emg_db_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      ped_db     <= 1'b0;
      ped_db_cnt <= 8'd0;
      emg_db     <= 1'b0;
      emg_db_cnt <= 8'd0;
      ped_db_d   <= 1'b0;
    end else begin
      ped_db     <= ped_db_nxt[8];
      ped_db_cnt <= ped_db_nxt[7:0];
      emg_db     <= emg_db_nxt[8];
      emg_db_cnt <= emg_db_nxt[7:0];
      ped_db_d   <= ped_db;
    end
  end

  // Output stage: emergency FSM and request latch
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      E_IDLE: begin
        if (emg_db) state_nxt = E_ACTIVE;
      end
      E_ACTIVE: begin
        if (!emg_db) begin
          state_nxt = E_HOLD;
          hold_nxt  = HOLD_LAST;
        end
      end
      E_HOLD: begin
        if (emg_db) begin
          state_nxt = E_ACTIVE;
          hold_nxt  = 8'd0;
        end else if (hold_cnt == 8'd0) begin
          state_nxt = E_IDLE;
        end else begin
          hold_nxt = hold_cnt - 8'd1;
        end
      end
      default: begin
        state_nxt = E_IDLE;
        hold_nxt  = 8'd0;
      end
    endcase

    press_rise   = ped_db & ~ped_db_d;
    accept       = press_rise && !pedestrian_request && !ped_served &&
                   (state == E_IDLE);
    enter_active = (state_nxt == E_ACTIVE) && (state != E_ACTIVE);

    // Serving or emergency pre-emption both beat a simultaneous press.
    req_nxt = pedestrian_request;
    if (ped_served || enter_active)
      req_nxt = 1'b0;
    else if (accept)
      req_nxt = 1'b1;

    count_nxt = accept ? sat_inc(req_count) : req_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= E_IDLE;
      hold_cnt           <= 8'd0;
      pedestrian_request <= 1'b0;
      req_count          <= 8'd0;
    end else begin
      state              <= state_nxt;
      hold_cnt           <= hold_nxt;
      pedestrian_request <= req_nxt;
      req_count          <= count_nxt;
    end
  end

  assign emergency = (state != E_IDLE);

endmodule

// File: tb/tb_ped_emerg_input_conditioner.sv
module tb_ped_emerg_input_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       ped_button_raw;
  logic       emergency_raw;
  logic       ped_served;
  logic       pedestrian_request;
  logic       emergency;
  logic [7:0] req_count;

  int checks = 0;
  int errors = 0;

  ped_emerg_input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .EMERG_HOLD_CYCLES(8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ped_button_raw    (ped_button_raw),
    .emergency_raw     (emergency_raw),
    .ped_served        (ped_served),
    .pedestrian_request(pedestrian_request),
    .emergency         (emergency),
    .req_count         (req_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ped;
    logic       emg;
    logic       srv;
    logic       exp_req;
    logic       exp_emg;
    logic [7:0] exp_cnt;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic r, input logic e, input logic [7:0] c);
    chk({name, ".req"}, {7'd0, pedestrian_request}, {7'd0, r});
    chk({name, ".emg"}, {7'd0, emergency}, {7'd0, e});
    chk({name, ".cnt"}, req_count, c);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    ped_button_raw = 1'b0;
    emergency_raw  = 1'b0;
    ped_served     = 1'b0;
    tick();
    chk_all("reset", 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    ped_button_raw = 1'b0;
    emergency_raw  = 1'b0;
    ped_served     = 1'b0;

    // press held 10 cycles: request appears on the 7th edge, then served
    for (int i = 0; i < NV; i++) begin
      vecs[i] = '{ped: 1'b0, emg: 1'b0, srv: 1'b0,
                  exp_req: 1'b0, exp_emg: 1'b0, exp_cnt: 8'd1};
      if (i <= 9)  vecs[i].ped = 1'b1;
      if (i <= 5)  vecs[i].exp_cnt = 8'd0;
      if (i >= 6 && i <= 10) vecs[i].exp_req = 1'b1;
      if (i == 11) vecs[i].srv = 1'b1;
    end

    do_reset();
    repeat (2) tick();

    for (int i = 0; i < NV; i++) begin
      ped_button_raw = vecs[i].ped;
      emergency_raw  = vecs[i].emg;
      ped_served     = vecs[i].srv;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_emg, vecs[i].exp_cnt);
    end

    // 3-cycle pulse is rejected
    do_reset();
    ped_button_raw = 1'b1;
    repeat (3) tick();
    ped_button_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_all("short_pulse", 1'b0, 1'b0, 8'd0);
    end

    // 1-0-1-0 bounce is rejected
    for (int k = 0; k < 4; k++) begin
      ped_button_raw = (k % 2 == 0);
      tick();
    end
    ped_button_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk_all("bounce", 1'b0, 1'b0, 8'd0);
    end

    // exactly DEBOUNCE_CYCLES wide pulse is accepted on edge 7
    ped_button_raw = 1'b1;
    repeat (4) tick();
    ped_button_raw = 1'b0;
    repeat (2) tick();
    chk_all("min_pulse_e6", 1'b0, 1'b0, 8'd0);
    tick();
    chk_all("min_pulse_e7", 1'b1, 1'b0, 8'd1);

    // second press while pending is ignored
    repeat (8) tick();
    ped_button_raw = 1'b1;
    repeat (8) tick();
    ped_button_raw = 1'b0;
    repeat (8) tick();
    chk_all("pending_ignore", 1'b1, 1'b0, 8'd1);
    ped_served = 1'b1;
    tick();
    ped_served = 1'b0;
    chk_all("served_clear", 1'b0, 1'b0, 8'd1);

    // press with ped_served held high is dropped
    do_reset();
    ped_served     = 1'b1;
    ped_button_raw = 1'b1;
    repeat (9) tick();
    ped_served = 1'b0;
    repeat (6) tick();
    ped_button_raw = 1'b0;
    repeat (8) tick();
    chk_all("served_wins", 1'b0, 1'b0, 8'd0);

    // emergency 20 cycles: high from edge 7 through edge 34
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      emergency_raw = (k <= 20);
      tick();
      chk($sformatf("emg_hold_e%0d", k), {7'd0, emergency}, {7'd0, (k >= 7 && k <= 34)});
    end

    // pending request pre-empted by emergency; press during hold discarded
    do_reset();
    ped_button_raw = 1'b1;
    repeat (6) tick();
    ped_button_raw = 1'b0;
    tick();
    chk_all("pre_pending", 1'b1, 1'b0, 8'd1);
    emergency_raw = 1'b1;
    repeat (6) tick();
    chk_all("pre_before_active", 1'b1, 1'b0, 8'd1);
    tick();
    chk_all("pre_active_entry", 1'b0, 1'b1, 8'd1);
    repeat (5) tick();
    emergency_raw = 1'b0;
    repeat (2) tick();
    ped_button_raw = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk({"hold_press.req"}, {7'd0, pedestrian_request}, 8'd0);
    end
    ped_button_raw = 1'b0;
    repeat (12) tick();
    chk_all("after_hold", 1'b0, 1'b0, 8'd1);

    // re-trigger during hold: no low glitch
    do_reset();
    emergency_raw = 1'b1;
    repeat (12) tick();
    chk({"retrig_active"}, {7'd0, emergency}, 8'd1);
    emergency_raw = 1'b0;
    repeat (7) tick();
    emergency_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk({"retrig_no_glitch"}, {7'd0, emergency}, 8'd1);
    end
    emergency_raw = 1'b0;
    repeat (20) tick();
    chk({"retrig_end"}, {7'd0, emergency}, 8'd0);

    // 300 accepted requests saturate at 255
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      ped_button_raw = 1'b1;
      repeat (5) tick();
      ped_button_raw = 1'b0;
      repeat (3) tick();
      if (i == 1) chk({"sat_first_req"}, {7'd0, pedestrian_request}, 8'd1);
      ped_served = 1'b1;
      tick();
      ped_served = 1'b0;
      repeat (5) tick();
      if (i == 10)  chk({"sat_cnt10"}, req_count, 8'd10);
      if (i == 254) chk({"sat_cnt254"}, req_count, 8'd254);
      if (i == 255) chk({"sat_cnt255"}, req_count, 8'd255);
    end
    chk({"sat_cnt300"}, req_count, 8'd255);

    // reset mid-operation with a pending request
    ped_button_raw = 1'b1;
    repeat (6) tick();
    ped_button_raw = 1'b0;
    tick();
    chk({"rst_pending_pre"}, {7'd0, pedestrian_request}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_pending", 1'b0, 1'b0, 8'd0);
    repeat (10) tick();
    chk_all("rst_pending_after", 1'b0, 1'b0, 8'd0);

    // reset mid-operation in E_HOLD
    emergency_raw = 1'b1;
    repeat (10) tick();
    emergency_raw = 1'b0;
    repeat (8) tick();
    chk({"rst_hold_pre"}, {7'd0, emergency}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all("rst_hold", 1'b0, 1'b0, 8'd0);
    repeat (10) tick();
    chk_all("rst_hold_after", 1'b0, 1'b0, 8'd0);

    // normal operation resumes
    ped_button_raw = 1'b1;
    repeat (6) tick();
    chk_all("resume_e6", 1'b0, 1'b0, 8'd0);
    tick();
    chk_all("resume_e7", 1'b1, 1'b0, 8'd1);
    ped_button_raw = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
